alu16b_sequencer: RTL and testbench
===================================

ALU16B_SEQUENCER -- requirements
Module: alu16b_sequencer

Interface
REQ-001 The block SHALL use the clock and reset ports below: one clock, with an asynchronous, active-low reset.
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous active-low reset.
REQ-002 The request side SHALL provide:
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  4  ALU opcode; 0..7 legal.
- req_a, req_b  input  16 each  signed operands.
- req_isBIEQ  input  1  zero-flag polarity select.
REQ-003 The ALU drive side SHALL provide, connected to alu16b:
- alu_A, alu_B  output  16 each  operands.
- alu_op  output  4  opcode.
- alu_isBIEQ  output  1  polarity select.
- alu_R  input  16  result.
- alu_isZero, alu_isNegative, alu_ovfl  input  1 each  flags.
REQ-004 The response side SHALL provide:
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_R  output  16  result.
- rsp_isZero, rsp_isNegative, rsp_ovfl  output  1 each  flags.
- rsp_err  output  1  illegal opcode.
REQ-005 The status side SHALL provide:
- ovfl_sticky  output  1  latched overflow.
- clr_sticky  input  1  clears ovfl_sticky.
- op_count  output  16  completed-response counter.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-007 In IDLE, req_ready SHALL be 1; when req_valid is also 1, the block captures op, a, b and isBIEQ into operand registers and moves to EXEC.
REQ-008 alu_A, alu_B, alu_op and alu_isBIEQ SHALL always be driven from the operand registers, never directly from the req_* inputs.
REQ-009 EXEC SHALL last exactly one cycle; at its closing edge the block registers alu_R and the flags into the rsp_* registers and moves to RESP.
REQ-010 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL hold stable until a cycle in which rsp_ready=1.
REQ-011 In RESP, req_ready SHALL equal rsp_ready.
- rsp_ready=1 and req_valid=1: capture the new request and go to EXEC.
- rsp_ready=1 and req_valid=0: go to IDLE.
- rsp_ready=0: stay in RESP.
REQ-012 Latency SHALL be 2 cycles, from the accepting edge to rsp_valid high; peak throughput SHALL be one response per 2 cycles.
REQ-013 rsp_ovfl SHALL equal alu_ovfl for op 2, 3 and 7, and SHALL be 0 for every other op.
REQ-014 For a captured op of 8..15:
- the operand registers are loaded normally, but in EXEC alu_op is forced to 0;
- the response is rsp_R=0, rsp_isZero=0, rsp_isNegative=0, rsp_ovfl=0, rsp_err=1.
REQ-015 rsp_err SHALL be 0 for legal ops.
REQ-016 rsp_isZero and rsp_isNegative SHALL be passed through exactly as the ALU supplies them; for isBIEQ=0 this includes the ALU's inverted zero sense.
REQ-017 ovfl_sticky SHALL set at any EXEC capture edge where the masked ovfl is 1, and SHALL clear on a clk edge with clr_sticky=1; if both occur in the same cycle, set wins.
REQ-018 op_count SHALL increment by 1 on every rsp_valid and rsp_ready handshake, including error responses, and SHALL wrap from 0xFFFF to 0x0000.
REQ-019 req_valid SHALL be ignored whenever req_ready=0, and no request SHALL be dropped or duplicated.

Reset
REQ-020 rst_n=0 SHALL immediately, without waiting for a clock edge, force the following:
- state to IDLE;
- req_ready=1 and rsp_valid=0;
- all rsp_* outputs, operand registers, alu_* outputs, ovfl_sticky and op_count to 0.
REQ-021 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response issued and no op_count change.
REQ-022 After rst_n deasserts, the block SHALL accept a request on the first clock edge.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Add overflow: op=2, a=0x7FFF, b=0x0001 -> 2 cycles later rsp_R=0x8000, rsp_ovfl=1, rsp_isNegative=1, ovfl_sticky=1, op_count=1 after handshake.
- Sub to zero: op=3, a=5, b=5, isBIEQ=1 -> rsp_R=0, rsp_isZero=1. Same with isBIEQ=0 -> rsp_isZero=0.
- Backpressure: rsp_ready held 0 for 3 cycles after rsp_valid -> rsp_* constant, req_ready=0, a new req_valid is not accepted; then rsp_ready=1 with req_valid=1 -> next result appears 2 cycles later.
- Illegal op: op=0xA, a=0x1234, b=0x0001 -> rsp_err=1, rsp_R=0, all flags 0, op_count increments.
- Ovfl masking and sticky: op=0 (AND) while the ALU model forces ovfl=1 -> rsp_ovfl=0; clr_sticky and an overflow in the same cycle -> ovfl_sticky stays 1.
- Reset mid-op: rst_n=0 during EXEC -> rsp_valid=0 and op_count=0 immediately; first request after release completes normally.

Source files
------------

// File: rtl/alu16b_sequencer.sv
// Request/response sequencer around an external 16-bit ALU: captures one
// request, drives the ALU for one cycle, and holds the registered result until the consumer takes it.
module alu16b_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_isBIEQ,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_op,
  output logic        alu_isBIEQ,
  input  logic [15:0] alu_R,
  input  logic        alu_isZero,
  input  logic        alu_isNegative,
  input  logic        alu_ovfl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_R,
  output logic        rsp_isZero,
  output logic        rsp_isNegative,
  output logic        rsp_ovfl,
  output logic        rsp_err,
  output logic        ovfl_sticky,
  input  logic        clr_sticky,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  op_reg;
  logic [15:0] a_reg, b_reg;
  logic        bieq_reg;
  logic [15:0] r_reg;
  logic        z_reg, n_reg, o_reg, e_reg;
  logic        sticky_reg;
  logic [15:0] count_reg;

  logic capture;
  logic handshake;
  logic illegal;
  logic arith;
  logic masked_ovfl;

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) begin
          handshake = 1'b1;
          if (req_valid) begin
            capture    = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the add/sub family reports overflow; illegal ops never reach this set.
  assign illegal     = op_reg[3];
  assign arith       = (op_reg == 4'd2) || (op_reg == 4'd3) || (op_reg == 4'd7);
  assign masked_ovfl = arith && alu_ovfl;

  assign alu_A      = a_reg;
  assign alu_B      = b_reg;
  assign alu_isBIEQ = bieq_reg;
  assign alu_op     = (state_reg == EXEC && illegal) ? 4'd0 : op_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= 4'd0;
      a_reg      <= 16'd0;
      b_reg      <= 16'd0;
      bieq_reg   <= 1'b0;
      r_reg      <= 16'd0;
      z_reg      <= 1'b0;
      n_reg      <= 1'b0;
      o_reg      <= 1'b0;
      e_reg      <= 1'b0;
      sticky_reg <= 1'b0;
      count_reg  <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        op_reg   <= req_op;
        a_reg    <= req_a;
        b_reg    <= req_b;
        bieq_reg <= req_isBIEQ;
      end
      if (state_reg == EXEC) begin
        r_reg <= illegal ? 16'd0 : alu_R;
        z_reg <= illegal ? 1'b0 : alu_isZero;
        n_reg <= illegal ? 1'b0 : alu_isNegative;
        o_reg <= masked_ovfl;
        e_reg <= illegal;
      end
      // Setting beats clearing when both land on the same edge.
      if (state_reg == EXEC && masked_ovfl) begin
        sticky_reg <= 1'b1;
      end else if (clr_sticky) begin
        sticky_reg <= 1'b0;
      end
      if (handshake) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  assign rsp_R          = r_reg;
  assign rsp_isZero     = z_reg;
  assign rsp_isNegative = n_reg;
  assign rsp_ovfl       = o_reg;
  assign rsp_err        = e_reg;
  assign ovfl_sticky    = sticky_reg;
  assign op_count       = count_reg;

endmodule

// File: tb/tb_alu16b_sequencer.sv
// Bench for alu16b_sequencer: a behavioural ALU feeds the DUT, a queue-based
// transaction model predicts every response, plus directed literal checks.
module tb_alu16b_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [15:0] req_a = 16'd0;
  logic [15:0] req_b = 16'd0;
  logic        req_isBIEQ = 1'b0;
  logic [15:0] alu_A, alu_B, alu_R;
  logic [3:0]  alu_op;
  logic        alu_isBIEQ, alu_isZero, alu_isNegative, alu_ovfl;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_R;
  logic        rsp_isZero, rsp_isNegative, rsp_ovfl, rsp_err;
  logic        ovfl_sticky;
  logic        clr_sticky = 1'b0;
  logic [15:0] op_count;

  logic force_ovfl = 1'b0;
  logic junk = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu16b_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_isBIEQ(req_isBIEQ),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_isBIEQ(alu_isBIEQ),
    .alu_R(alu_R), .alu_isZero(alu_isZero), .alu_isNegative(alu_isNegative),
    .alu_ovfl(alu_ovfl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_R(rsp_R),
    .rsp_isZero(rsp_isZero), .rsp_isNegative(rsp_isNegative),
    .rsp_ovfl(rsp_ovfl), .rsp_err(rsp_err),
    .ovfl_sticky(ovfl_sticky), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  // External ALU: {R, isZero, isNegative, ovfl}; non-arithmetic ops emit a junk ovfl bit.
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic bieq,
                                         input logic frc, input logic jk);
    logic [15:0] r;
    logic        o;
    o = jk;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin r = a + b; o = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd3: begin r = a - b; o = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b);
      4'd6: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd7: begin r = b - a; o = (b[15] != a[15]) && (r[15] != b[15]); end
      default: r = 16'hDEAD;
    endcase
    o = o | frc;
    return {r, bieq ? (r == 16'd0) : (r != 16'd0), r[15], o};
  endfunction

  always_comb begin
    {alu_R, alu_isZero, alu_isNegative, alu_ovfl} =
      alu_fn(alu_op, alu_A, alu_B, alu_isBIEQ, force_ovfl, junk);
  end

  typedef struct {
    logic [15:0] r;
    logic        z, n, o, e;
    logic [3:0]  op;
    logic [15:0] a, b;
    int          vis;
  } exp_t;

  exp_t        q[$];
  logic        sticky_m = 1'b0;
  logic [15:0] cnt_m = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t predict(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic bieq, input int vis);
    exp_t        t;
    logic [18:0] f;
    t.op = op; t.a = a; t.b = b; t.vis = vis;
    if (op > 4'd7) begin
      t.r = 16'd0; t.z = 1'b0; t.n = 1'b0; t.o = 1'b0; t.e = 1'b1;
    end else begin
      f = alu_fn(op, a, b, bieq, force_ovfl, 1'b0);
      t.r = f[18:3]; t.z = f[2]; t.n = f[1];
      t.o = (op == 4'd2 || op == 4'd3 || op == 4'd7) ? f[0] : 1'b0;
      t.e = 1'b0;
    end
    return t;
  endfunction

  // Compare at the falling edge, then decide what the next rising edge does.
  task automatic cycle();
    logic vexp, rexp, hs, acc, exec_o, in_exec;
    @(negedge clk);
    cyc++;
    vexp    = (q.size() > 0) && (q[0].vis <= cyc);
    in_exec = (q.size() > 0) && (q[0].vis == cyc + 1);
    rexp    = (q.size() == 0) || (vexp && rsp_ready);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, vexp});
    chk("req_ready", {31'd0, req_ready}, {31'd0, rexp});
    chk("ovfl_sticky", {31'd0, ovfl_sticky}, {31'd0, sticky_m});
    chk("op_count", {16'd0, op_count}, {16'd0, cnt_m});
    if (vexp) begin
      chk("rsp_R", {16'd0, rsp_R}, {16'd0, q[0].r});
      chk("rsp_flags", {27'd0, rsp_isZero, rsp_isNegative, rsp_ovfl, rsp_err},
          {27'd0, q[0].z, q[0].n, q[0].o, q[0].e});
    end
    if (in_exec) begin
      chk("alu_A", {16'd0, alu_A}, {16'd0, q[0].a});
      chk("alu_B", {16'd0, alu_B}, {16'd0, q[0].b});
      chk("alu_op", {28'd0, alu_op}, {28'd0, (q[0].op > 4'd7) ? 4'd0 : q[0].op});
    end
    if (rst_n) begin
      exec_o = in_exec && q[0].o;
      hs     = vexp && rsp_ready;
      acc    = req_valid && rexp;
      if (exec_o) sticky_m = 1'b1;
      else if (clr_sticky) sticky_m = 1'b0;
      if (hs) begin
        $display("rsp %0d: op=%0h a=%h b=%h R=%h z=%b n=%b o=%b err=%b", cnt_m,
                 q[0].op, q[0].a, q[0].b, rsp_R, rsp_isZero, rsp_isNegative, rsp_ovfl, rsp_err);
        void'(q.pop_front());
        cnt_m = cnt_m + 16'd1;
      end
      if (acc) q.push_back(predict(req_op, req_a, req_b, req_isBIEQ, cyc + 2));
    end
    @(posedge clk);
    #1;
    junk = 1'($urandom);
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic bieq);
    req_op = op; req_a = a; req_b = b; req_isBIEQ = bieq;
    req_valid = 1'b1; rsp_ready = 1'b0;
    cycle();
    req_valid = 1'b0;
    cycle();
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    sticky_m = 1'b0;
    cnt_m = 16'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cycle();
    cycle();
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_op_count", {16'd0, op_count}, 32'd0);
    chk("reset_alu_A", {16'd0, alu_A}, 32'd0);
    rst_n = 1'b1;

    send(4'd2, 16'h7FFF, 16'h0001, 1'b1);
    chk("add_ovf_R", {16'd0, rsp_R}, 32'h8000);
    chk("add_ovf_ovfl", {31'd0, rsp_ovfl}, 32'd1);
    chk("add_ovf_neg", {31'd0, rsp_isNegative}, 32'd1);
    chk("add_ovf_sticky", {31'd0, ovfl_sticky}, 32'd1);
    take();
    chk("add_ovf_count", {16'd0, op_count}, 32'd1);

    send(4'd3, 16'd5, 16'd5, 1'b1);
    chk("sub_zero_R", {16'd0, rsp_R}, 32'd0);
    chk("sub_zero_bieq1", {31'd0, rsp_isZero}, 32'd1);
    take();
    send(4'd3, 16'd5, 16'd5, 1'b0);
    chk("sub_zero_bieq0", {31'd0, rsp_isZero}, 32'd0);
    take();

    send(4'hA, 16'h1234, 16'h0001, 1'b1);
    chk("illegal_err", {31'd0, rsp_err}, 32'd1);
    chk("illegal_R", {16'd0, rsp_R}, 32'd0);
    chk("illegal_flags", {29'd0, rsp_isZero, rsp_isNegative, rsp_ovfl}, 32'd0);
    take();
    chk("illegal_count", {16'd0, op_count}, 32'd4);

    send(4'd2, 16'd100, 16'd23, 1'b1);
    req_op = 4'd3; req_a = 16'd50; req_b = 16'd8; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("bp_R_held", {16'd0, rsp_R}, 32'd123);
    chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0; req_valid = 1'b0;
    cycle();
    chk("bp_next_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_next_R", {16'd0, rsp_R}, 32'd42);
    take();

    force_ovfl = 1'b1;
    send(4'd0, 16'hFFFF, 16'h0F0F, 1'b1);
    chk("mask_R", {16'd0, rsp_R}, 32'h0F0F);
    chk("mask_ovfl", {31'd0, rsp_ovfl}, 32'd0);
    take();
    force_ovfl = 1'b0;

    clr_sticky = 1'b1;
    cycle();
    chk("sticky_cleared", {31'd0, ovfl_sticky}, 32'd0);
    send(4'd2, 16'h7FFF, 16'h7FFF, 1'b1);
    chk("sticky_set_wins", {31'd0, ovfl_sticky}, 32'd1);
    clr_sticky = 1'b0;
    take();

    req_op = 4'd2; req_a = 16'd1; req_b = 16'd2; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_count", {16'd0, op_count}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_sticky", {31'd0, ovfl_sticky}, 32'd0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    send(4'd4, 16'hF0F0, 16'hFF00, 1'b1);
    chk("post_rst_R", {16'd0, rsp_R}, 32'h0FF0);
    take();
    chk("post_rst_count", {16'd0, op_count}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 2) != 0);
      rsp_ready  = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      req_op     = 4'($urandom_range(0, 15));
      req_isBIEQ = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin req_a = 16'h7FFF; req_b = 16'($urandom); end
        1: begin req_a = 16'h8000; req_b = 16'($urandom); end
        2: begin req_a = 16'($urandom); req_b = req_a; end
        default: begin req_a = 16'($urandom); req_b = 16'($urandom); end
      endcase
      cycle();
    end
    req_valid = 1'b0; rsp_ready = 1'b1; clr_sticky = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
